// File: rtl/axi_mb_pkg.sv
// Shared types and constants for the AXI read mailbox: channel structs, response/burst codes, FSM states.
package axi_mb_pkg;

    localparam int unsigned ID_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
        logic [1:0]      resp;
        logic            last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    typedef enum logic { R_IDLE, R_BURST } r_state_e;
    typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_e;

endpackage

// File: rtl/axi_mb_wr_sink.sv
// Write-side drain: accepts AW, swallows W beats up to last, answers one SLVERR B. Nothing is stored.
module axi_mb_wr_sink
    import axi_mb_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            aw_valid_i,
    input  logic [ID_W-1:0] aw_id_i,
    input  logic            w_valid_i,
    input  logic            w_last_i,
    input  logic            b_ready_i,
    output logic            aw_ready_o,
    output logic            w_ready_o,
    output logic            b_valid_o,
    output logic [ID_W-1:0] b_id_o
);

    w_state_e        state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            aw_ready_q, aw_ready_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= W_IDLE;
            id_q       <= '0;
            aw_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            aw_ready_q <= aw_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            W_IDLE: if (aw_valid_i && aw_ready_q) begin
                id_d    = aw_id_i;
                state_d = W_DATA;
            end
            W_DATA: if (w_valid_i && w_last_i) state_d = W_RESP;
            W_RESP: if (b_ready_i) state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase
        // Registered so reset holds aw_ready low and no valid->ready path exists.
        aw_ready_d = (state_d == W_IDLE);
    end

    assign aw_ready_o = aw_ready_q;
    assign w_ready_o  = (state_q == W_DATA);
    assign b_valid_o  = (state_q == W_RESP);
    assign b_id_o     = id_q;

endmodule

// File: rtl/axi_rd_mailbox.sv
// AXI4 read-only mailbox: host-loaded 64-bit register bank served over AR/R; writes drained with SLVERR.
module axi_rd_mailbox
    import axi_mb_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'hBC00_0000,
    parameter int unsigned NUM_REGS  = 8,
    localparam int unsigned IW       = $clog2(NUM_REGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  req_t          axi_req_i,
    output resp_t         axi_resp_o,
    input  logic          mb_we_i,
    input  logic [IW-1:0] mb_idx_i,
    input  logic [63:0]   mb_wdata_i,
    output logic [15:0]   rd_count_o
);

    logic [NUM_REGS-1:0][63:0] regs_q;

    r_state_e        state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      len_q, len_d, beat_q, beat_d;
    logic [1:0]      burst_q, burst_d, err_q, err_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            r_valid_q, r_valid_d, r_last_q, r_last_d, ar_ready_q, ar_ready_d;
    logic [63:0]     r_data_q, r_data_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [IW-1:0]   ar_idx, idx_nxt;
    logic [1:0]      ar_err;
    logic [7:0]      beat_nxt;

    logic            aw_ready, w_ready, b_valid;
    logic [ID_W-1:0] b_id;

    logic unused_req;
    assign unused_req = ^{axi_req_i.ar.addr[2:0], axi_req_i.aw.addr, axi_req_i.aw.len,
                          axi_req_i.aw.size, axi_req_i.aw.burst, axi_req_i.w.data, axi_req_i.w.strb};

    always_ff @(posedge clk_i) begin
        if (rst_i) regs_q <= '0;
        else if (mb_we_i) regs_q[mb_idx_i] <= mb_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= R_IDLE;
            id_q       <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            burst_q    <= '0;
            err_q      <= '0;
            idx_q      <= '0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            ar_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            burst_q    <= burst_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_data_q   <= r_data_d;
            ar_ready_q <= ar_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        ar_idx = axi_req_i.ar.addr[IW+2:3];
        if (axi_req_i.ar.addr[63:IW+3] != BASE_ADDR[63:IW+3]) ar_err = RESP_DECERR;
        else if (axi_req_i.ar.size != 3'd3)                   ar_err = RESP_SLVERR;
        else                                                  ar_err = RESP_OKAY;
        // Reserved burst code falls through to FIXED behaviour.
        idx_nxt  = (burst_q == BURST_INCR || burst_q == BURST_WRAP) ? idx_q + IW'(1) : idx_q;
        beat_nxt = beat_q + 8'd1;
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        err_d     = err_q;
        idx_d     = idx_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        r_data_d  = r_data_q;
        cnt_d     = cnt_q;
        case (state_q)
            R_IDLE: if (axi_req_i.ar_valid && ar_ready_q) begin
                id_d      = axi_req_i.ar.id;
                len_d     = axi_req_i.ar.len;
                burst_d   = axi_req_i.ar.burst;
                err_d     = ar_err;
                idx_d     = ar_idx;
                beat_d    = '0;
                r_valid_d = 1'b1;
                r_last_d  = (axi_req_i.ar.len == 8'd0);
                r_data_d  = (ar_err == RESP_OKAY) ? regs_q[ar_idx] : '0;
                state_d   = R_BURST;
            end
            R_BURST: if (r_valid_q && axi_req_i.r_ready) begin
                if (r_last_q) begin
                    r_valid_d = 1'b0;
                    r_last_d  = 1'b0;
                    cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    state_d   = R_IDLE;
                end else begin
                    // Data sampled from the pre-edge regfile, so a same-edge host write is not seen.
                    idx_d    = idx_nxt;
                    beat_d   = beat_nxt;
                    r_last_d = (beat_nxt == len_q);
                    r_data_d = (err_q == RESP_OKAY) ? regs_q[idx_nxt] : '0;
                end
            end
            default: state_d = R_IDLE;
        endcase
        ar_ready_d = (state_d == R_IDLE);
    end

    axi_mb_wr_sink u_wr_sink (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .aw_valid_i (axi_req_i.aw_valid),
        .aw_id_i    (axi_req_i.aw.id),
        .w_valid_i  (axi_req_i.w_valid),
        .w_last_i   (axi_req_i.w.last),
        .b_ready_i  (axi_req_i.b_ready),
        .aw_ready_o (aw_ready),
        .w_ready_o  (w_ready),
        .b_valid_o  (b_valid),
        .b_id_o     (b_id)
    );

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.ar_ready = ar_ready_q;
        axi_resp_o.r_valid  = r_valid_q;
        axi_resp_o.r.id     = id_q;
        axi_resp_o.r.data   = r_data_q;
        axi_resp_o.r.resp   = err_q;
        axi_resp_o.r.last   = r_last_q;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.b_valid  = b_valid;
        axi_resp_o.b.id     = b_id;
        axi_resp_o.b.resp   = b_valid ? RESP_SLVERR : RESP_OKAY;
    end

    assign rd_count_o = cnt_q;

endmodule

// File: tb/tb_axi_rd_mailbox.sv
// Scoreboard bench for axi_rd_mailbox: stimulus pushes expected R/B responses, a monitor pops and compares.
module tb_axi_rd_mailbox;
    import axi_mb_pkg::*;

    localparam logic [63:0] BASE = 64'hBC00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    req_t        req;
    resp_t       resp;
    logic        ar_valid = 1'b0;
    ax_chan_t    ar = '0;
    logic        r_ready = 1'b1;
    logic        aw_valid = 1'b0;
    logic [3:0]  aw_id = '0;
    logic        w_valid = 1'b0;
    logic        w_last = 1'b0;
    logic [63:0] w_data = '0;
    logic        b_ready = 1'b1;
    logic        mb_we = 1'b0;
    logic [2:0]  mb_idx = '0;
    logic [63:0] mb_wdata = '0;
    logic [15:0] rd_count;
    bit          rr_rand = 1'b0;

    int checks = 0;
    int passes = 0;

    r_chan_t     r_q[$];
    b_chan_t     b_q[$];
    logic [63:0] mregs[8];
    int          mcount = 0;

    always #5 clk = ~clk;

    always_comb begin
        req          = '0;
        req.ar       = ar;
        req.ar_valid = ar_valid;
        req.r_ready  = r_ready;
        req.aw.id    = aw_id;
        req.aw_valid = aw_valid;
        req.w.data   = w_data;
        req.w.last   = w_last;
        req.w_valid  = w_valid;
        req.b_ready  = b_ready;
    end

    axi_rd_mailbox #(.BASE_ADDR(BASE), .NUM_REGS(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_req_i  (req),
        .axi_resp_o (resp),
        .mb_we_i    (mb_we),
        .mb_idx_i   (mb_idx),
        .mb_wdata_i (mb_wdata),
        .rd_count_o (rd_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always begin
        @(posedge clk);
        #1;
        r_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        b_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: R beats and B responses against the scoreboard, plus hold stability of stalled beats.
    r_chan_t held_r;
    bit      held = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("r_hold_valid", 64'(resp.r_valid), 64'd1);
                chk("r_hold_data", resp.r.data, held_r.data);
                chk("r_hold_last", 64'(resp.r.last), 64'(held_r.last));
            end
            if (resp.r_valid && r_ready) begin
                held = 1'b0;
                if (r_q.size() == 0) begin
                    chk("r_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    r_chan_t e;
                    e = r_q.pop_front();
                    chk("r_id", 64'(resp.r.id), 64'(e.id));
                    chk("r_data", resp.r.data, e.data);
                    chk("r_resp", 64'(resp.r.resp), 64'(e.resp));
                    chk("r_last", 64'(resp.r.last), 64'(e.last));
                end
            end else if (resp.r_valid) begin
                held = 1'b1;
                held_r = resp.r;
            end else begin
                held = 1'b0;
            end
            if (resp.b_valid && b_ready) begin
                if (b_q.size() == 0) begin
                    chk("b_unexpected", 64'd1, 64'd0);
                end else begin
                    b_chan_t eb;
                    eb = b_q.pop_front();
                    chk("b_id", 64'(resp.b.id), 64'(eb.id));
                    chk("b_resp", 64'(resp.b.resp), 64'(eb.resp));
                end
            end
        end
    end

    task automatic wait_ready(input int ch, input string nm);
        int t = 0;
        forever begin
            logic rdy;
            @(negedge clk);
            rdy = (ch == 0) ? resp.ar_ready : (ch == 1) ? resp.aw_ready : resp.w_ready;
            if (rdy) return;
            if (++t > 200) begin
                chk(nm, 64'd0, 64'd1);
                return;
            end
        end
    endtask

    task automatic host_wr(input int idx, input logic [63:0] d);
        @(posedge clk);
        #1;
        mb_we = 1'b1; mb_idx = 3'(idx); mb_wdata = d;
        @(posedge clk);
        #1;
        mb_we = 1'b0;
        mregs[idx] = d;
    endtask

    // Model: beat k reads the bank as it stood before that beat's launch; a host write
    // in the accept cycle therefore lands after beat 0 and is seen from beat 1 on.
    task automatic issue_ar(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id,
                            input bit hw, input int hidx, input logic [63:0] hdata);
        int idx;
        logic [1:0] rs;
        idx = int'((addr >> 3) % 8);
        if ((addr >> 6) != (BASE >> 6)) rs = RESP_DECERR;
        else if (size != 3'd3)           rs = RESP_SLVERR;
        else                             rs = RESP_OKAY;
        for (int b = 0; b <= int'(len); b++) begin
            r_q.push_back('{id: id, data: (rs == RESP_OKAY) ? mregs[idx] : 64'd0, resp: rs, last: (b == int'(len))});
            if (b == 0 && hw) mregs[hidx] = hdata;
            if (burst == BURST_INCR || burst == BURST_WRAP) idx = (idx + 1) % 8;
        end
        mcount++;
        @(posedge clk);
        #1;
        ar_valid = 1'b1;
        ar = '{id: id, addr: addr, len: len, size: size, burst: burst};
        wait_ready(0, "ar_ready_timeout");
        if (hw) begin
            mb_we = 1'b1; mb_idx = 3'(hidx); mb_wdata = hdata;
        end
        @(posedge clk);
        #1;
        ar_valid = 1'b0;
        mb_we = 1'b0;
        chk("r_valid_next_cycle", 64'(resp.r_valid), 64'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (r_q.size() != 0 || b_q.size() != 0) begin
            @(negedge clk);
            if (++t > 3000) begin
                chk("drain_timeout", 64'(r_q.size() + b_q.size()), 64'd0);
                r_q.delete();
                b_q.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
        chk("rd_count", 64'(rd_count), 64'(mcount));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
        chk("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
        chk("rst_r_valid", 64'(resp.r_valid), 64'd0);
        chk("rst_b_valid", 64'(resp.b_valid), 64'd0);
        chk("rst_r_data", resp.r.data, 64'd0);
        chk("rst_rd_count", 64'(rd_count), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_ready_after_rst", 64'(resp.ar_ready), 64'd1);

        // 1: single beat
        host_wr(0, 64'hA5);
        issue_ar(BASE, 8'd0, BURST_INCR, 3'd3, 4'd1, 1'b0, 0, '0);
        wait_idle();

        // 2: INCR wrapping past the last register
        for (int i = 0; i < 8; i++) host_wr(i, 64'(i + 1));
        issue_ar(BASE + 64'h30, 8'd3, BURST_INCR, 3'd3, 4'd2, 1'b0, 0, '0);
        wait_idle();

        // 3: FIXED with random backpressure
        rr_rand = 1'b1;
        issue_ar(BASE + 64'h30, 8'd2, BURST_FIXED, 3'd3, 4'd9, 1'b0, 0, '0);
        wait_idle();

        // 4: decode error and size error
        issue_ar(64'h7000_0000, 8'd1, BURST_INCR, 3'd3, 4'd4, 1'b0, 0, '0);
        wait_idle();
        issue_ar(BASE + 64'h8, 8'd0, BURST_INCR, 3'd2, 4'd5, 1'b0, 0, '0);
        wait_idle();

        // 5: write drained during a read burst
        issue_ar(BASE, 8'd15, BURST_WRAP, 3'd3, 4'd6, 1'b0, 0, '0);
        @(posedge clk);
        #1;
        w_valid = 1'b1; w_last = 1'b0; w_data = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            chk("w_ready_before_aw", 64'(resp.w_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        aw_valid = 1'b1; aw_id = 4'd3;
        b_q.push_back('{id: 4'd3, resp: RESP_SLVERR});
        wait_ready(1, "aw_ready_timeout");
        @(posedge clk);
        #1;
        aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1; w_last = (i == 3); w_data = {$urandom, $urandom};
            wait_ready(2, "w_ready_timeout");
            @(posedge clk);
            #1;
            w_valid = 1'b0; w_last = 1'b0;
        end
        wait_idle();
        issue_ar(BASE, 8'd7, BURST_INCR, 3'd3, 4'd7, 1'b0, 0, '0);
        wait_idle();

        // randomized bursts, including occasional off-window, bad size and reserved burst codes
        for (int n = 0; n < 20; n++) begin
            logic [63:0] a;
            logic [2:0]  sz;
            repeat ($urandom_range(0, 2)) host_wr(int'($urandom_range(0, 7)), {$urandom, $urandom});
            a  = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : BASE + 64'($urandom_range(0, 63));
            sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            issue_ar(a, 8'($urandom_range(0, 20)), 2'($urandom_range(0, 3)), sz,
                     4'($urandom_range(0, 15)), 1'b0, 0, '0);
            wait_idle();
        end
        issue_ar(BASE + 64'h18, 8'd255, BURST_INCR, 3'd3, 4'd8, 1'b0, 0, '0);
        wait_idle();

        // 6: host write colliding with the launch of a FIXED beat
        rr_rand = 1'b0;
        host_wr(5, 64'h1111_2222);
        issue_ar(BASE + 64'h28, 8'd1, BURST_FIXED, 3'd3, 4'd10, 1'b1, 5, 64'hDEAD_BEEF);
        wait_idle();

        // reset in the middle of a burst
        rr_rand = 1'b1;
        issue_ar(BASE, 8'd7, BURST_INCR, 3'd3, 4'd11, 1'b0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_r_valid", 64'(resp.r_valid), 64'd0);
        chk("midrst_rd_count", 64'(rd_count), 64'd0);
        r_q.delete();
        b_q.delete();
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mcount = 0;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_beat", 64'(resp.r_valid), 64'd0);
        end
        issue_ar(BASE + 64'h10, 8'd0, BURST_INCR, 3'd3, 4'd12, 1'b0, 0, '0);
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
